crc_code_read_checker: RTL and testbench
========================================

// Module: crc_code_read_checker
// PURPOSE
//  Read-path stage for the CRC-protected memory. Sits directly downstream of mem_crc_code.
//  - Accepts a read request and fetches the 12-bit codeword {data[7:0], crc[3:0]}.
//  - Serially divides the codeword by the CRC-4 polynomial, one bit per clock, MSB first.
//  - Returns data_out plus error_detected, with a one-cycle data_valid strobe.
// PARAMETERS
//  READ_LATENCY  1     memory read latency in clocks from mem_read_addr to mem_read_data; legal values 0 or 1
//  CRC_POLY      4'h3  low 4 bits of the generator polynomial; default is x^4+x+1
// PORTS
//  clk             in   1   single clock; all flops on posedge
//  rst             in   1   synchronous, active-high reset
//  read            in   1   read request, sampled on posedge
//  addr_in         in   4   read address, sampled together with read
//  mem_write_busy  in   1   write controller busy; reads are held off while this is high
//  mem_read_addr   out  4   registered address driven to the memory read port
//  mem_read_data   in   12  codeword from memory: [11:4] data, [3:0] crc
//  read_busy       out  1   high from request acceptance until data_valid inclusive
//  data_valid      out  1   one-cycle strobe; data_out and error_detected are valid this cycle
//  data_out        out  8   checked data; holds its value until the next DONE
//  error_detected  out  1   high when the remainder is nonzero; holds until the next DONE
//  err_count       out  8   saturating error count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; pending=0; every output is 0, including mem_read_addr and the shift/remainder registers.
//  - FSM states: IDLE -> FETCH -> SHIFT -> DONE -> IDLE.
//  - IDLE: if read=1 and mem_write_busy=0:
//      latch addr_in into mem_read_addr; go to FETCH.
//  - IDLE: if read=1 and mem_write_busy=1:
//      latch addr_in; set pending=1; stay in IDLE.
//      When pending=1 and mem_write_busy=0, go to FETCH and clear pending.
//  - read while read_busy=1 is ignored (no queue). A new read while pending overwrites the latched address.
//  - FETCH lasts READ_LATENCY+1 cycles. On its last cycle, capture mem_read_data into the 12-bit shift
//    register and clear the 4-bit remainder.
//  - SHIFT lasts exactly 12 cycles (4-bit counter, 0..11). Each cycle:
//      fb  = rem[3] ^ sr[11]
//      rem = {rem[2:0],1'b0} ^ (fb ? CRC_POLY : 4'h0)
//      sr  = sr << 1
//  - DONE lasts 1 cycle:
//      data_valid=1; data_out=codeword[11:4] (kept in a separate hold register);
//      error_detected = |rem. Then return to IDLE.
//  - Latency: request sampled at edge k -> data_valid high in cycle k+READ_LATENCY+14 (15 at the default).
//  - Back-to-back: a read sampled during DONE is ignored; the next read is accepted in IDLE.
//  - rst asserted mid-operation aborts immediately to reset values; no data_valid is issued.
//  - Widths: the remainder is exactly 4 bits; no arithmetic is wider than 12 bits.
// CONFIGURATION
//  CRC_READ_ERR_COUNT_EN defined:
//    err_count increments by 1 on each DONE with error_detected=1; saturates at 8'hFF; cleared only by rst.
//  CRC_READ_ERR_COUNT_EN undefined:
//    the counter is not built; err_count is tied to 8'h00.
// STRUCTURE
//  - Package crc_code_pkg: CW_WIDTH=12, DATA_WIDTH=8, CRC_WIDTH=4, DEFAULT_POLY=4'h3,
//    state enum {IDLE,FETCH,SHIFT,DONE}.
//  - Sub-module crc_code_lfsr_step: combinational single-bit divide step, (rem, in_bit, poly) -> rem_next.
//    Intended for reuse by the encoder.
//  - Top level holds the FSM, shift register, bit counter, pending flag and output hold registers.
// TESTING
//  - Clean read: memory[3]=12'h013 (data 0x01); read addr 3 -> data_valid at cycle +15; data_out=8'h01; error_detected=0.
//  - Single-bit fault: memory[3]=12'h012 -> data_out=8'h01; error_detected=1; err_count 0->1 (macro on).
//  - High bit: memory[7]=12'h80E -> data_out=8'h80; error_detected=0. Flip bit 11 (12'h00E) -> error_detected=1.
//  - Write hold-off: read addr 2 while mem_write_busy=1 for 13 cycles -> read_busy=1 throughout.
//    FETCH starts the cycle after busy drops; mem_read_addr=2.
//  - Ignore/abort: second read during SHIFT -> ignored; exactly one data_valid pulse.
//    rst pulsed in SHIFT -> all outputs 0, no data_valid.
//  - Saturation (macro on): 300 faulty reads -> err_count=8'hFF. Macro off -> err_count stays 8'h00.

Source files
------------

// File: rtl/crc_code_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | crc_code_pkg                                                     |
// | Shared widths, default polynomial and FSM states for the CRC-4   |
// | protected memory read path.                                      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package crc_code_pkg;

  localparam int CW_WIDTH   = 12;
  localparam int DATA_WIDTH = 8;
  localparam int CRC_WIDTH  = 4;

  localparam logic [CRC_WIDTH-1:0] DEFAULT_POLY = 4'h3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage : crc_code_pkg
`default_nettype wire

// File: rtl/crc_code_lfsr_step.sv
`default_nettype none
// +------------------------------------------------------------------+
// | crc_code_lfsr_step                                               |
// | Combinational single-bit CRC division step, shared with encoder. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module crc_code_lfsr_step
  import crc_code_pkg::*;
(
  input  logic [CRC_WIDTH-1:0] rem,
  input  logic                 in_bit,
  input  logic [CRC_WIDTH-1:0] poly,
  output logic [CRC_WIDTH-1:0] rem_next
);

  logic w_fb;

  assign w_fb     = rem[CRC_WIDTH-1] ^ in_bit;
  assign rem_next = {rem[CRC_WIDTH-2:0], 1'b0} ^ (w_fb ? poly : '0);

endmodule : crc_code_lfsr_step
`default_nettype wire

// File: rtl/crc_code_read_checker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | crc_code_read_checker                                            |
// | Fetches a 12-bit codeword, divides it serially by the CRC-4      |
// | polynomial and reports data plus an error flag.                  |
// | Optional: CRC_READ_ERR_COUNT_EN builds the saturating err_count. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module crc_code_read_checker
  import crc_code_pkg::*;
#(
  parameter int                   READ_LATENCY = 1,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY     = DEFAULT_POLY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read,
  input  logic [3:0]            addr_in,
  input  logic                  mem_write_busy,
  output logic [3:0]            mem_read_addr,
  input  logic [CW_WIDTH-1:0]   mem_read_data,
  output logic                  read_busy,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  error_detected,
  output logic [7:0]            err_count
);

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_pending;
  logic [3:0]            r_cnt;
  logic [3:0]            r_addr;
  logic [CW_WIDTH-1:0]   r_sr;
  logic [CRC_WIDTH-1:0]  r_rem;
  logic [CRC_WIDTH-1:0]  w_rem_next;
  logic [DATA_WIDTH-1:0] r_data_hold;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_error;
  logic                  w_go;
  logic                  w_fetch_last;
  logic                  w_shift_last;

  // A held-off request launches as soon as the write side goes idle.
  assign w_go         = (r_state == IDLE) && !mem_write_busy && (read || r_pending);
  assign w_fetch_last = (r_state == FETCH) && (r_cnt == 4'(READ_LATENCY));
  assign w_shift_last = (r_state == SHIFT) && (r_cnt == 4'(CW_WIDTH - 1));

  crc_code_lfsr_step u_step (
    .rem      (r_rem),
    .in_bit   (r_sr[CW_WIDTH-1]),
    .poly     (CRC_POLY),
    .rem_next (w_rem_next)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    data_valid   = 1'b0;
    read_busy    = r_pending || (r_state != IDLE);
    case (r_state)
      IDLE:    if (w_go) w_state_next = FETCH;
      FETCH:   if (w_fetch_last) w_state_next = SHIFT;
      SHIFT:   if (w_shift_last) w_state_next = DONE;
      DONE: begin
        data_valid   = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending   <= 1'b0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_sr        <= '0;
      r_rem       <= '0;
      r_data_hold <= '0;
      r_data_out  <= '0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (read) r_addr <= addr_in;
          if (w_go) begin
            r_pending <= 1'b0;
            r_cnt     <= '0;
          end else if (read && mem_write_busy) begin
            r_pending <= 1'b1;
          end
        end
        FETCH: begin
          r_cnt <= r_cnt + 4'd1;
          if (w_fetch_last) begin
            r_sr        <= mem_read_data;
            r_rem       <= '0;
            r_data_hold <= mem_read_data[CW_WIDTH-1 -: DATA_WIDTH];
            r_cnt       <= '0;
          end
        end
        SHIFT: begin
          r_rem <= w_rem_next;
          r_sr  <= {r_sr[CW_WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
          // Outputs update only on entry to DONE so they hold between reads.
          if (w_shift_last) begin
            r_data_out <= r_data_hold;
            r_error    <= |w_rem_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_read_addr  = r_addr;
  assign data_out       = r_data_out;
  assign error_detected = r_error;

`ifdef CRC_READ_ERR_COUNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (w_shift_last && (|w_rem_next) && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'h00;
`endif

endmodule : crc_code_read_checker
`default_nettype wire

// File: tb/tb_crc_code_read_checker.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_crc_code_read_checker                                         |
// | Self-checking bench with a polynomial long-division reference.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_crc_code_read_checker;

  localparam int         RL   = 1;
  localparam logic [3:0] POLY = 4'h3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        read = 1'b0;
  logic [3:0]  addr_in = '0;
  logic        mem_write_busy = 1'b0;
  logic [3:0]  mem_read_addr;
  logic [11:0] mem_read_data;
  logic        read_busy;
  logic        data_valid;
  logic [7:0]  data_out;
  logic        error_detected;
  logic [7:0]  err_count;

  logic [11:0] mem [16];
  int n_tests = 0;
  int n_fail  = 0;
  int exp_err = 0;

  crc_code_read_checker #(.READ_LATENCY(RL), .CRC_POLY(POLY)) dut (
    .clk            (clk),
    .rst            (rst),
    .read           (read),
    .addr_in        (addr_in),
    .mem_write_busy (mem_write_busy),
    .mem_read_addr  (mem_read_addr),
    .mem_read_data  (mem_read_data),
    .read_busy      (read_busy),
    .data_valid     (data_valid),
    .data_out       (data_out),
    .error_detected (error_detected),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  // Memory with one clock of read latency.
  always @(posedge clk) mem_read_data <= mem[mem_read_addr];

  // Codeword modulo the generator x^4 + POLY, by plain long division.
  function automatic logic [3:0] poly_mod(input logic [11:0] cw);
    logic [11:0] r;
    logic [11:0] g;
    r = cw;
    g = {7'b0, 1'b1, POLY};
    for (int i = 11; i >= 4; i--)
      if (r[i]) r = r ^ (g << (i - 4));
    return r[3:0];
  endfunction

  function automatic logic [11:0] make_cw(input logic [7:0] d);
    return {d, poly_mod({d, 4'b0})};
  endfunction

  function automatic int next_err(input int cur, input logic err);
`ifdef CRC_READ_ERR_COUNT_EN
    return (err && cur < 255) ? cur + 1 : cur;
`else
    return 0;
`endif
  endfunction

  task automatic do_read(input logic [3:0] a, output int lat);
    @(negedge clk);
    read    = 1'b1;
    addr_in = a;
    @(negedge clk);
    read = 1'b0;
    lat  = 1;
    while (!data_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({mem_read_addr, read_busy, data_valid, data_out, error_detected, err_count} !== 23'h0) begin
      n_fail++;
      $display("FAIL reset: addr=%h busy=%b dv=%b data=%h err=%b cnt=%h, all required 0",
               mem_read_addr, read_busy, data_valid, data_out, error_detected, err_count);
    end
    rst     = 1'b0;
    exp_err = 0;
  endtask

  task automatic test_directed();
    logic [3:0]  addrs [4];
    logic [11:0] cws   [4];
    logic        exp_e;
    int          lat;
    addrs = '{4'd3, 4'd3, 4'd7, 4'd7};
    cws   = '{12'h013, 12'h012, 12'h80E, 12'h00E};
    for (int i = 0; i < 4; i++) begin
      mem[addrs[i]] = cws[i];
      do_read(addrs[i], lat);
      exp_e   = (poly_mod(cws[i]) != 4'h0);
      exp_err = next_err(exp_err, exp_e);
      n_tests++;
      if (lat !== RL + 14 || data_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL directed%0d latency: got %0d dv=%b, required %0d", i, lat, data_valid, RL + 14);
      end
      n_tests++;
      if (data_out !== cws[i][11:4] || error_detected !== exp_e) begin
        n_fail++;
        $display("FAIL directed%0d result: data=%h err=%b, required data=%h err=%b",
                 i, data_out, error_detected, cws[i][11:4], exp_e);
      end
      n_tests++;
      if (err_count !== 8'(exp_err)) begin
        n_fail++;
        $display("FAIL directed%0d err_count: got %0d, required %0d", i, err_count, exp_err);
      end
      @(negedge clk);
      n_tests++;
      if (data_valid !== 1'b0 || read_busy !== 1'b0 || data_out !== cws[i][11:4]) begin
        n_fail++;
        $display("FAIL directed%0d strobe/hold: dv=%b busy=%b data=%h, required 0 0 %h",
                 i, data_valid, read_busy, data_out, cws[i][11:4]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0]  a;
    logic [11:0] cw;
    logic        exp_e;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      a  = 4'($urandom_range(0, 15));
      cw = ($urandom_range(0, 1) == 1) ? make_cw(8'($urandom)) : 12'($urandom);
      mem[a] = cw;
      do_read(a, lat);
      exp_e   = (poly_mod(cw) != 4'h0);
      exp_err = next_err(exp_err, exp_e);
      n_tests++;
      if (lat !== RL + 14 || data_out !== cw[11:4] || error_detected !== exp_e ||
          err_count !== 8'(exp_err)) begin
        n_fail++;
        $display("FAIL random%0d cw=%h: lat=%0d data=%h err=%b cnt=%0d, required lat=%0d data=%h err=%b cnt=%0d",
                 i, cw, lat, data_out, error_detected, err_count, RL + 14, cw[11:4], exp_e, exp_err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hold_off();
    logic       ok;
    logic [3:0] first_addr;
    int         lat;
    mem[2] = make_cw(8'hA5);
    mem[5] = make_cw(8'h3C);
    @(negedge clk);
    mem_write_busy = 1'b1;
    read           = 1'b1;
    addr_in        = 4'd2;
    ok             = 1'b1;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      read = 1'b0;
      if (read_busy !== 1'b1 || data_valid !== 1'b0) ok = 1'b0;
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL hold_off busy: read_busy not held high (or data_valid seen) during write busy");
    end
    mem_write_busy = 1'b0;
    @(negedge clk);
    first_addr = mem_read_addr;
    lat = 1;
    while (!data_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_tests++;
    if (first_addr !== 4'd2 || lat !== RL + 14 || data_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL hold_off result: addr=%0d lat=%0d data=%h, required 2 %0d a5",
               first_addr, lat, data_out, RL + 14);
    end
    // A second request while still held off replaces the address.
    @(negedge clk);
    mem_write_busy = 1'b1;
    read           = 1'b1;
    addr_in        = 4'd2;
    @(negedge clk);
    addr_in = 4'd5;
    @(negedge clk);
    read = 1'b0;
    repeat (3) @(negedge clk);
    mem_write_busy = 1'b0;
    lat = 0;
    while (!data_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_tests++;
    if (data_valid !== 1'b1 || data_out !== 8'h3C) begin
      n_fail++;
      $display("FAIL pending_overwrite: dv=%b data=%h, required 1 3c", data_valid, data_out);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore();
    int         pulses;
    logic [7:0] seen;
    mem[4] = make_cw(8'h5A);
    mem[6] = make_cw(8'hC3);
    @(negedge clk);
    read    = 1'b1;
    addr_in = 4'd4;
    @(negedge clk);
    read = 1'b0;
    repeat (6) @(negedge clk);
    read    = 1'b1;
    addr_in = 4'd6;
    @(negedge clk);
    read   = 1'b0;
    pulses = 0;
    seen   = 8'h00;
    for (int i = 0; i < 40; i++) begin
      if (data_valid) begin
        pulses++;
        seen = data_out;
      end
      @(negedge clk);
    end
    n_tests++;
    if (pulses !== 1 || seen !== 8'h5A) begin
      n_fail++;
      $display("FAIL ignore_in_shift: pulses=%0d data=%h, required 1 5a", pulses, seen);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int pulses;
    mem[10] = make_cw(8'h11);
    mem[11] = make_cw(8'h22);
    do_read(4'd10, lat);
    read    = 1'b1;
    addr_in = 4'd11;
    @(negedge clk);
    read   = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (data_valid || read_busy) pulses++;
      @(negedge clk);
    end
    n_tests++;
    if (pulses !== 0 || data_out !== 8'h11) begin
      n_fail++;
      $display("FAIL ignore_in_done: active_cycles=%0d data=%h, required 0 11", pulses, data_out);
    end
    do_read(4'd11, lat);
    n_tests++;
    if (lat !== RL + 14 || data_out !== 8'h22) begin
      n_fail++;
      $display("FAIL after_done_read: lat=%0d data=%h, required %0d 22", lat, data_out, RL + 14);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int pulses;
    mem[8] = 12'h012;
    @(negedge clk);
    read    = 1'b1;
    addr_in = 4'd8;
    @(negedge clk);
    read = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_err = 0;
    n_tests++;
    if ({mem_read_addr, read_busy, data_valid, data_out, error_detected, err_count} !== 23'h0) begin
      n_fail++;
      $display("FAIL abort_outputs: addr=%h busy=%b dv=%b data=%h err=%b cnt=%h, all required 0",
               mem_read_addr, read_busy, data_valid, data_out, error_detected, err_count);
    end
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      if (data_valid) pulses++;
      @(negedge clk);
    end
    n_tests++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL abort_no_valid: pulses=%0d, required 0", pulses);
    end
  endtask

  task automatic test_saturation();
    int lat;
    mem[9] = 12'h012;
    for (int i = 0; i < 300; i++) begin
      do_read(4'd9, lat);
      exp_err = next_err(exp_err, 1'b1);
      n_tests++;
      if (data_valid !== 1'b1 || error_detected !== 1'b1 || err_count !== 8'(exp_err)) begin
        n_fail++;
        $display("FAIL saturation%0d: dv=%b err=%b cnt=%0d, required 1 1 %0d",
                 i, data_valid, error_detected, err_count, exp_err);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 12'h000;
    test_reset();
    test_directed();
    test_random();
    test_hold_off();
    test_ignore();
    test_back_to_back();
    test_abort();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_crc_code_read_checker
`default_nettype wire
